// File: rtl/if_id_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface if_id_stage_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic                imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_id_stage.sv
// DLX instruction fetch plus IF/ID pipeline register, with wait-state tolerant imem handshake,
// a one-entry skid buffer for stalls and a DRAIN state that retires requests abandoned by redirects.
module if_id_stage #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  if_id_stage_if.master       imem,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc4,
  output logic                id_valid,
  output logic [5:0]          id_opcode,
  output logic [5:0]          id_funct,
  output logic                fetch_busy
);

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [31:0]         hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0] hold_pc4_q, hold_pc4_d;
  logic                hold_valid_q, hold_valid_d;
  logic [31:0]         id_instr_q, id_instr_d;
  logic [PC_WIDTH-1:0] id_pc4_q, id_pc4_d;
  logic                id_valid_q, id_valid_d;

  logic                req;
  logic                complete;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] redirect_aligned;

  // Requests pause while the skid buffer is occupied, so at most one word is ever buffered.
  assign req              = !reset && !hold_valid_q;
  assign complete         = req && imem.imem_ready;
  assign pc_inc           = addr_q + PC_WIDTH'(4);
  assign redirect_aligned = redirect_pc & ~PC_WIDTH'(3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (redirect && req && !imem.imem_ready) state_d = DRAIN;
      DRAIN:   if (imem.imem_ready) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    fetch_busy = (state_q == DRAIN);
  end

  always_comb begin
    addr_d       = addr_q;
    pend_pc_d    = pend_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    hold_valid_d = hold_valid_q;
    id_instr_d   = id_instr_q;
    id_pc4_d     = id_pc4_q;
    id_valid_d   = id_valid_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          id_instr_d   = NOP_INSTR;
          id_valid_d   = 1'b0;
          hold_valid_d = 1'b0;
          // An in-flight request cannot be retargeted; park the target until it retires.
          if (req && !imem.imem_ready) pend_pc_d = redirect_aligned;
          else                         addr_d    = redirect_aligned;
        end else if (stall) begin
          if (complete) begin
            hold_instr_d = imem.imem_rdata;
            hold_pc4_d   = pc_inc;
            hold_valid_d = 1'b1;
            addr_d       = pc_inc;
          end
        end else if (hold_valid_q) begin
          id_instr_d   = hold_instr_q;
          id_pc4_d     = hold_pc4_q;
          id_valid_d   = 1'b1;
          hold_valid_d = 1'b0;
        end else if (complete) begin
          id_instr_d = imem.imem_rdata;
          id_pc4_d   = pc_inc;
          id_valid_d = 1'b1;
          addr_d     = pc_inc;
        end else begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (redirect) pend_pc_d = redirect_aligned;
        if (imem.imem_ready) addr_d = redirect ? redirect_aligned : pend_pc_q;
        if (!stall) begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc4_q   <= '0;
      hold_valid_q <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc4_q     <= '0;
      id_valid_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      pend_pc_q    <= pend_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      hold_valid_q <= hold_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
      id_valid_q   <= id_valid_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr_q;
  assign id_instr       = id_instr_q;
  assign id_pc4         = id_pc4_q;
  assign id_valid       = id_valid_q;
  assign id_opcode      = id_instr_q[31:26];
  assign id_funct       = id_instr_q[5:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: memory returns word = address; every expected value is hand-derived.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic        fetch_busy;
  logic        memReady;

  int nChecks = 0;
  int nFails  = 0;

  if_id_stage_if #(.PC_WIDTH(32)) imem ();

  assign imem.imem_rdata = imem.imem_addr;
  assign imem.imem_ready = memReady;

  if_id_stage #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem       (imem.master),
    .id_instr   (id_instr),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_funct   (id_funct),
    .fetch_busy (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic stl, input logic redir,
                               input logic [31:0] rpc, input logic rdy);
    reset       = rst;
    stall       = stl;
    redirect    = redir;
    redirect_pc = rpc;
    memReady    = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("rst_req", imem.imem_req, 32'd0);
    checkOutput("rst_valid", id_valid, 32'd0);
    checkOutput("rst_instr", id_instr, 32'h0);
    checkOutput("rst_pc4", id_pc4, 32'h0);
    checkOutput("rst_addr", imem.imem_addr, 32'h0);
    checkOutput("rst_busy", fetch_busy, 32'd0);

    // Zero-wait streaming
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t1_req", imem.imem_req, 32'd1);
    checkOutput("t1_addr0", imem.imem_addr, 32'h0);
    tick();
    checkOutput("t1_instr0", id_instr, 32'h0);
    checkOutput("t1_pc4_0", id_pc4, 32'h4);
    checkOutput("t1_valid0", id_valid, 32'd1);
    checkOutput("t1_addr4", imem.imem_addr, 32'h4);
    tick();
    checkOutput("t1_instr4", id_instr, 32'h4);
    checkOutput("t1_pc4_4", id_pc4, 32'h8);
    checkOutput("t1_valid4", id_valid, 32'd1);
    checkOutput("t1_addr8", imem.imem_addr, 32'h8);

    // Two wait states on 0x8
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t2_valid_w1", id_valid, 32'd0);
    checkOutput("t2_addr_w1", imem.imem_addr, 32'h8);
    tick();
    checkOutput("t2_valid_w2", id_valid, 32'd0);
    checkOutput("t2_addr_w2", imem.imem_addr, 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t2_addr_w3", imem.imem_addr, 32'h8);
    tick();
    checkOutput("t2_instr8", id_instr, 32'h8);
    checkOutput("t2_pc4_8", id_pc4, 32'hC);
    checkOutput("t2_valid8", id_valid, 32'd1);
    tick();
    checkOutput("t2_instrC", id_instr, 32'hC);
    checkOutput("t2_addr10", imem.imem_addr, 32'h10);

    // Stall for 3 cycles while 0x10 completes into the skid buffer
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t3_hold_instr", id_instr, 32'hC);
    checkOutput("t3_hold_valid", id_valid, 32'd1);
    checkOutput("t3_req_low", imem.imem_req, 32'd0);
    checkOutput("t3_addr14", imem.imem_addr, 32'h14);
    tick();
    checkOutput("t3_hold_instr2", id_instr, 32'hC);
    checkOutput("t3_req_low2", imem.imem_req, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t3_req_low3", imem.imem_req, 32'd0);
    tick();
    checkOutput("t3_instr10", id_instr, 32'h10);
    checkOutput("t3_pc4_14", id_pc4, 32'h14);
    checkOutput("t3_valid10", id_valid, 32'd1);
    checkOutput("t3_req_back", imem.imem_req, 32'd1);
    checkOutput("t3_addr14b", imem.imem_addr, 32'h14);
    tick();
    checkOutput("t3_instr14", id_instr, 32'h14);
    checkOutput("t3_addr18", imem.imem_addr, 32'h18);

    // Redirect to 0x100 while 0x18 is waiting
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_busy", fetch_busy, 32'd1);
    checkOutput("t4_addr_kept", imem.imem_addr, 32'h18);
    checkOutput("t4_valid0", id_valid, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t4_drop_valid", id_valid, 32'd0);
    checkOutput("t4_busy_done", fetch_busy, 32'd0);
    checkOutput("t4_addr100", imem.imem_addr, 32'h100);
    tick();
    checkOutput("t4_instr100", id_instr, 32'h100);
    checkOutput("t4_pc4_104", id_pc4, 32'h104);
    checkOutput("t4_valid100", id_valid, 32'd1);

    // Redirect and stall together with a misaligned target
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h203, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t5_valid0", id_valid, 32'd0);
    checkOutput("t5_instr_nop", id_instr, 32'h0);
    checkOutput("t5_addr200", imem.imem_addr, 32'h200);
    checkOutput("t5_req_hold_clr", imem.imem_req, 32'd1);
    tick();
    checkOutput("t5_instr200", id_instr, 32'h200);
    checkOutput("t5_pc4_204", id_pc4, 32'h204);

    // Reset in the middle of a wait on 0x40
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t6_addr40", imem.imem_addr, 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_req_rst_comb", imem.imem_req, 32'd0);
    tick();
    checkOutput("t6_req_rst", imem.imem_req, 32'd0);
    checkOutput("t6_valid_rst", id_valid, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t6_addr_resetpc", imem.imem_addr, 32'h0);
    checkOutput("t6_req_after", imem.imem_req, 32'd1);
    tick();
    checkOutput("t6_instr0", id_instr, 32'h0);
    checkOutput("t6_pc4_4", id_pc4, 32'h4);
    checkOutput("t6_valid0", id_valid, 32'd1);

    // PC+4 wraps at the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap_instr", id_instr, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", id_pc4, 32'h0);
    checkOutput("wrap_opcode", id_opcode, 32'h3F);
    checkOutput("wrap_funct", id_funct, 32'h3C);
    checkOutput("wrap_addr0", imem.imem_addr, 32'h0);

    // A second redirect in DRAIN replaces the pending target
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("dr_busy", fetch_busy, 32'd1);
    checkOutput("dr_addr_kept", imem.imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("dr_addr400", imem.imem_addr, 32'h400);
    checkOutput("dr_valid0", id_valid, 32'd0);
    tick();
    checkOutput("dr_instr400", id_instr, 32'h400);
    checkOutput("dr_pc4_404", id_pc4, 32'h404);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
